ssd_display_ctrl: RTL
=====================

Name: ssd_display_ctrl

Overview:
- Decides what the two-digit seven-segment display shows and drives the digit driver's digit_one/digit_two/one_en/two_en inputs.
- Arbitrates three sources by priority: "HI" message, then latched test score, then live countdown timer, otherwise blank.
- Converts binary values to BCD with a sequential converter.
- Applies leading-zero blanking, score blinking and message hold timing.

Parameters:
- TICK_DIV, 10_000_000: clk cycles per timing tick (100 ms at 100 MHz).
- MSG_HOLD_TICKS, 20: ticks the "HI" message is held.
- BLINK_TICKS, 5: ticks per blink half-period in SCORE.
- SCORE_BLINKS, 6: blink half-periods before the score goes steady.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- timer_val  in  7  countdown value, binary; values >99 saturate to 99.
- timer_active  in  1  level; timer is displayable.
- score_val  in  7  score, binary; values >99 saturate to 99.
- score_valid  in  1  pulse; latch score_val and request score display.
- score_clear  in  1  pulse; drop the latched score.
- msg_req  in  1  pulse; show "HI".
- digit_one  out  4  tens/left glyph code (0-9, 0xA=H, 0xB=I).
- digit_two  out  4  ones/right glyph code.
- one_en  out  1  left digit enable.
- two_en  out  1  right digit enable.
- src  out  2  shown source: 0 blank, 1 timer, 2 score, 3 msg.

Behaviour:
- Reset (async assert, sync deassert):
  - state BLANK; digit_one=digit_two=0; one_en=two_en=0; src=0.
  - score_latched=0; prescaler, hold and blink counters =0.
  - Any in-flight conversion is aborted.
- All outputs are registered.
- States: BLANK, TIMER, SCORE, MSG. Re-evaluated every cycle.
- Next-state priority: MSG (msg_req, or hold not expired) > SCORE (score_latched) > TIMER (timer_active) > BLANK.
- Prescaler:
  - Restarts at 0 on every state entry.
  - Emits a tick when it reaches TICK_DIV-1, then wraps.
- MSG state:
  - digit_one=0xA, digit_two=0xB, both enables 1, src=3, from the cycle after msg_req.
  - Exits after exactly MSG_HOLD_TICKS ticks.
  - msg_req while in MSG restarts the hold and prescaler.
- score_valid: latches the saturated score_val, sets score_latched, starts a conversion.
  - If it arrives in SCORE, it also restarts the blink sequence.
- score_clear clears score_latched.
  - score_valid and score_clear in the same cycle: valid wins.
  - msg_req and score_valid in the same cycle: score latches, state enters MSG, score is shown after MSG.
- SCORE state:
  - Enables blink: off for odd half-periods of BLINK_TICKS ticks, for SCORE_BLINKS half-periods. Half-period 0 is on.
  - After that the enables stay steady on. src=2.
- TIMER state:
  - A conversion starts whenever the saturated timer_val differs from the last converted timer value.
  - If the value changes during a busy conversion, it is caught by the comparison after done.
  - src=1.
- Conversion rules:
  - In TIMER/SCORE, digits update only on converter done. Prior digits hold until then, including after a state change.
  - Entering TIMER/SCORE with no valid conversion for that source shows enables=0 until done.
- Leading-zero blanking (TIMER/SCORE): tens==0 forces one_en=0. Value 0 shows "0" on the right digit.
- timer_active dropping in TIMER: next state BLANK (or SCORE/MSG per priority).
- BLANK: enables 0, digits held, src=0.
- Converter latency: done occurs tens+2 cycles after start (max 11). One conversion at a time; pending requests are served in priority order after done.

Decomposition:
- Shared package ssd_pkg:
  - state enum.
  - src codes (SRC_BLANK/TIMER/SCORE/MSG).
  - glyph constants GLYPH_H=4'hA, GLYPH_I=4'hB.
  - MAX_VAL=99.
- Sub-module bin2bcd_seq:
  - Ports: clk, rst_n, start, bin[6:0], busy, done pulse, tens[3:0], ones[3:0].
  - Operation: load on start, then subtract 10 per cycle while remainder ≥10.
  - Ignores start while busy.

Test Plan:
Parameters for all scenarios: TICK_DIV=4, MSG_HOLD_TICKS=3, BLINK_TICKS=2, SCORE_BLINKS=4.
1. Reset release with all inputs 0 -> src=0, one_en=two_en=0, digits 0; holds indefinitely.
2. timer_active=1, timer_val=57 -> within 9 cycles digit_one=5, digit_two=7, both en, src=1. timer_val=7 -> one_en=0, digit_two=7. timer_val=120 -> shows 99.
3. score_valid with score_val=42 while in TIMER:
   - src=2 next cycle; digits 4/2 within 8 cycles.
   - Enables on 8 cycles, off 8, on 8, off 8, then steady on.
   - score_clear -> returns to TIMER.
4. msg_req during SCORE -> next cycle digits A/B, both en, src=3 for exactly 12 cycles, then back to SCORE with digits 4/2. Repeat msg_req at cycle 6 -> MSG lasts 6+12 cycles total.
5. Same-cycle msg_req+score_valid(score_val=3), then score_valid+score_clear -> MSG first, then SCORE with one_en=0, digit_two=3; score_latched stays 1.
6. rst_n asserted mid-conversion (timer_val=95) -> outputs go to reset values asynchronously. After release, conversion restarts and shows 9/5.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the two-digit seven-segment display controller.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_TIMER,
    ST_SCORE,
    ST_MSG
  } state_t;

  localparam logic [1:0] SRC_BLANK = 2'd0;
  localparam logic [1:0] SRC_TIMER = 2'd1;
  localparam logic [1:0] SRC_SCORE = 2'd2;
  localparam logic [1:0] SRC_MSG   = 2'd3;

  localparam logic [3:0] GLYPH_H = 4'hA;
  localparam logic [3:0] GLYPH_I = 4'hB;

  localparam logic [6:0] MAX_VAL = 7'd99;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/ssd_display_ctrl_bin2bcd.sv
// Sequential binary-to-BCD converter: one subtraction of ten per cycle,
// done pulses tens+2 cycles after the start cycle.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;
  logic [3:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem  <= '0;
      cnt  <= '0;
      tens <= '0;
      ones <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          rem  <= bin;
          cnt  <= '0;
        end
      end else if (rem >= 7'd10) begin
        rem <= rem - 7'd10;
        cnt <= cnt + 4'd1;
      end else begin
        busy <= 1'b0;
        done <= 1'b1;
        tens <= cnt;
        ones <= rem[3:0];
      end
    end
  end

endmodule

// File: rtl/ssd_display_ctrl.sv
// Display source arbiter: "HI" message > latched score > live timer > blank,
// with leading-zero blanking, score blinking and message hold timing.
module ssd_display_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 10_000_000,
  parameter int unsigned MSG_HOLD_TICKS = 20,
  parameter int unsigned BLINK_TICKS    = 5,
  parameter int unsigned SCORE_BLINKS   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] timer_val,
  input  logic       timer_active,
  input  logic [6:0] score_val,
  input  logic       score_valid,
  input  logic       score_clear,
  input  logic       msg_req,
  output logic [3:0] digit_one,
  output logic [3:0] digit_two,
  output logic       one_en,
  output logic       two_en,
  output logic [1:0] src
);

  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W  = (MSG_HOLD_TICKS > 1) ? $clog2(MSG_HOLD_TICKS) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HALF_W  = $clog2(SCORE_BLINKS + 1);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MSG_HOLD_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [HALF_W-1:0]  HALF_END   = HALF_W'(SCORE_BLINKS);

  state_t              state, nxt;
  logic [PRE_W-1:0]    presc, presc_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [BLINK_W-1:0]  blink_cnt, blink_nxt;
  logic [HALF_W-1:0]   half_cnt, half_nxt;
  logic [3:0]          d1_nxt, d2_nxt;
  logic                one_nxt, two_nxt;
  logic [1:0]          src_nxt;

  logic                score_latched, score_pend, score_cv, timer_cv;
  logic [6:0]          score_reg, last_treq, tsat;
  logic                treq_valid, conv_score;
  logic [3:0]          score_t, score_o, timer_t, timer_o;

  logic                busy, done, conv_start, score_req, timer_req;
  logic [6:0]          conv_bin;
  logic [3:0]          bcd_tens, bcd_ones;

  logic                tick, hold_done, restart, score_set, blink_on;
  logic                s_done, t_done, s_ok, t_ok;
  logic [3:0]          s_tens, s_ones, t_tens, t_ones;

  assign tsat      = sat99(timer_val);
  assign tick      = (presc == PRE_LAST);
  assign score_set = score_valid | (score_latched & ~score_clear);
  assign hold_done = (state == ST_MSG) && tick && (hold_cnt == HOLD_LAST);

  // Fresh results are forwarded straight from the converter on its done cycle.
  assign s_done = done &  conv_score & ~score_pend;
  assign t_done = done & ~conv_score;
  assign s_ok   = score_cv | s_done;
  assign t_ok   = timer_cv | t_done;
  assign s_tens = s_done ? bcd_tens : score_t;
  assign s_ones = s_done ? bcd_ones : score_o;
  assign t_tens = t_done ? bcd_tens : timer_t;
  assign t_ones = t_done ? bcd_ones : timer_o;

  assign score_req  = score_valid | score_pend;
  assign timer_req  = (nxt == ST_TIMER) && (!treq_valid || (tsat != last_treq));
  assign conv_start = !busy && (score_req || timer_req);
  assign conv_bin   = score_valid ? sat99(score_val) : (score_pend ? score_reg : tsat);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (busy),
    .done  (done),
    .tens  (bcd_tens),
    .ones  (bcd_ones)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    nxt       = ST_BLANK;
    presc_nxt = tick ? '0 : presc + PRE_W'(1);
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    half_nxt  = half_cnt;
    d1_nxt    = digit_one;
    d2_nxt    = digit_two;
    one_nxt   = 1'b0;
    two_nxt   = 1'b0;
    src_nxt   = SRC_BLANK;

    if (msg_req || (state == ST_MSG && !hold_done)) nxt = ST_MSG;
    else if (score_set)                            nxt = ST_SCORE;
    else if (timer_active)                         nxt = ST_TIMER;

    restart = (nxt != state) || msg_req || (score_valid && state == ST_SCORE);

    if (restart) begin
      presc_nxt = '0;
      hold_nxt  = '0;
      blink_nxt = '0;
      half_nxt  = '0;
    end else if (tick) begin
      if (state == ST_MSG) hold_nxt = hold_cnt + HOLD_W'(1);
      if (state == ST_SCORE && half_cnt < HALF_END) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_nxt = '0;
          half_nxt  = half_cnt + HALF_W'(1);
        end else begin
          blink_nxt = blink_cnt + BLINK_W'(1);
        end
      end
    end

    blink_on = !(half_nxt[0] && (half_nxt < HALF_END));

    case (nxt)
      ST_MSG: begin
        d1_nxt  = GLYPH_H;
        d2_nxt  = GLYPH_I;
        one_nxt = 1'b1;
        two_nxt = 1'b1;
        src_nxt = SRC_MSG;
      end
      ST_SCORE: begin
        src_nxt = SRC_SCORE;
        if (s_ok) begin
          d1_nxt  = s_tens;
          d2_nxt  = s_ones;
          two_nxt = blink_on;
          one_nxt = blink_on && (s_tens != 4'd0);
        end
      end
      ST_TIMER: begin
        src_nxt = SRC_TIMER;
        if (t_ok) begin
          d1_nxt  = t_tens;
          d2_nxt  = t_ones;
          two_nxt = 1'b1;
          one_nxt = (t_tens != 4'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BLANK;
      presc     <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      half_cnt  <= '0;
      digit_one <= '0;
      digit_two <= '0;
      one_en    <= 1'b0;
      two_en    <= 1'b0;
      src       <= SRC_BLANK;
    end else begin
      state     <= nxt;
      presc     <= presc_nxt;
      hold_cnt  <= hold_nxt;
      blink_cnt <= blink_nxt;
      half_cnt  <= half_nxt;
      digit_one <= d1_nxt;
      digit_two <= d2_nxt;
      one_en    <= one_nxt;
      two_en    <= two_nxt;
      src       <= src_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_latched <= 1'b0;
      score_pend    <= 1'b0;
      score_reg     <= '0;
      score_cv      <= 1'b0;
      score_t       <= '0;
      score_o       <= '0;
      timer_cv      <= 1'b0;
      timer_t       <= '0;
      timer_o       <= '0;
      last_treq     <= '0;
      treq_valid    <= 1'b0;
      conv_score    <= 1'b0;
    end else begin
      if (score_valid) begin
        score_latched <= 1'b1;
        score_reg     <= sat99(score_val);
      end else if (score_clear) begin
        score_latched <= 1'b0;
      end

      if (conv_start && score_req) score_pend <= 1'b0;
      else if (score_valid)        score_pend <= 1'b1;
      else if (score_clear)        score_pend <= 1'b0;

      if (conv_start) begin
        conv_score <= score_req;
        if (!score_req) begin
          last_treq  <= tsat;
          treq_valid <= 1'b1;
        end
      end

      if (s_done) begin
        score_t  <= bcd_tens;
        score_o  <= bcd_ones;
        score_cv <= 1'b1;
      end
      if (t_done) begin
        timer_t  <= bcd_tens;
        timer_o  <= bcd_ones;
        timer_cv <= 1'b1;
      end
      // A new or dropped score invalidates any cached result, even one landing now.
      if (score_valid || score_clear) score_cv <= 1'b0;
    end
  end

endmodule
